// File: rtl/bcnn_conv_mc.sv
// bcnn_conv_mc: streaming KxK binary convolution, F parallel filters, popcount + threshold
module bcnn_conv_mc #(
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_FILTERS = 4,
  parameter int SUM_WIDTH   = $clog2(KERNEL_SIZE*KERNEL_SIZE+1)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             pixel_in,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic                             xnor_mode,
  input  logic [NUM_FILTERS*KERNEL_SIZE*KERNEL_SIZE-1:0] weight_bits,
  input  logic [NUM_FILTERS*SUM_WIDTH-1:0] threshold,
  output logic [NUM_FILTERS*SUM_WIDTH-1:0] popcount,
  output logic [NUM_FILTERS-1:0]           act_bits,
  output logic                             valid_out,
  input  logic                             out_ready,
  output logic                             frame_done
);
  localparam int K  = KERNEL_SIZE;
  localparam int KK = K*K;
  localparam int SW = SUM_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH-1);
  localparam logic [CW-1:0] C_K1   = CW'(K-1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT-1);
  localparam logic [RW-1:0] R_K1   = RW'(K-1);

  logic                    r_run;
  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic [IMG_WIDTH-1:0]    r_lb [K-1];
  logic [KK-1:0]           r_win;
  logic                    r_v0, r_l0, r_v1, r_l1, r_vo, r_lo, r_fd;
  logic [NUM_FILTERS*SW-1:0] r_pc1, r_pc2, w_pc;
  logic [NUM_FILTERS-1:0]  r_act, w_act;
  logic [KK-1:0]           w_match;
  logic [K-1:0]            w_col;
  logic                    w_en, w_acc;

  assign ready_in   = !r_vo || out_ready;
  assign w_en       = ready_in;
  assign w_acc      = w_en && valid_in && r_run;
  assign popcount   = r_pc2;
  assign act_bits   = r_act;
  assign valid_out  = r_vo;
  assign frame_done = r_fd;

  // release of reset is taken through a flop so acceptance starts on the second edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_run <= 1'b0;
    else          r_run <= 1'b1;

  // current column: line buffers (oldest row first) with the incoming pixel at the bottom
  always_comb begin
    w_col = {pixel_in, {(K-1){1'b0}}};
    for (int r = 0; r < K-1; r++) w_col[r] = r_lb[r][r_col];
  end

  // per-filter match vector and popcount of the current window
  always_comb begin
    w_pc    = '0;
    w_match = '0;
    for (int f = 0; f < NUM_FILTERS; f++) begin
      w_match = xnor_mode ? ~(r_win ^ weight_bits[f*KK +: KK]) : (r_win & weight_bits[f*KK +: KK]);
      for (int b = 0; b < KK; b++) w_pc[f*SW +: SW] = w_pc[f*SW +: SW] + SW'(w_match[b]);
    end
  end

  // threshold compare on the registered popcounts
  always_comb begin
    w_act = '0;
    for (int f = 0; f < NUM_FILTERS; f++) w_act[f] = r_pc1[f*SW +: SW] >= threshold[f*SW +: SW];
  end

  // counters, line buffers, window and the two-stage result pipeline
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_col <= '0;
      r_row <= '0;
      r_win <= '0;
      for (int r = 0; r < K-1; r++) r_lb[r] <= '0;
      {r_v0, r_l0, r_v1, r_l1, r_vo, r_lo} <= '0;
      r_pc1 <= '0;
      r_pc2 <= '0;
      r_act <= '0;
    end else if (w_en) begin
      r_v0  <= w_acc && r_row >= R_K1 && r_col >= C_K1;
      r_l0  <= w_acc && r_row == R_LAST && r_col == C_LAST;
      r_v1  <= r_v0;
      r_l1  <= r_l0;
      r_pc1 <= w_pc;
      r_vo  <= r_v1;
      r_lo  <= r_l1;
      if (r_v1) begin
        r_pc2 <= r_pc1;
        r_act <= w_act;
      end
      if (w_acc) begin
        r_col <= r_col == C_LAST ? '0 : r_col + 1'b1;
        if (r_col == C_LAST) r_row <= r_row == R_LAST ? '0 : r_row + 1'b1;
        for (int r = 0; r < K-1; r++) r_lb[r][r_col] <= w_col[r+1];
        for (int r = 0; r < K; r++) r_win[r*K +: K] <= {w_col[r], r_win[r*K+1 +: K-1]};
      end
    end

  // pulse once the last patch of a frame has been taken downstream
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_fd <= 1'b0;
    else          r_fd <= r_vo && out_ready && r_lo;
endmodule

// File: tb/tb_bcnn_conv_mc.sv
// tb_bcnn_conv_mc: directed tests for the binary convolution block
module tb_bcnn_conv_mc;
  localparam int W = 5, H = 5, K = 3, F = 2, SW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic pixel_in = 1'b0, valid_in = 1'b0, xnor_mode = 1'b0;
  logic out_ready = 1'b1;
  logic ready_in, valid_out, frame_done;
  logic [F*K*K-1:0] weight_bits = '0;
  logic [F*SW-1:0]  threshold = '0;
  logic [F*SW-1:0]  popcount;
  logic [F-1:0]     act_bits;

  logic b_pixel = 1'b0, b_valid = 1'b0;
  logic b_ready, b_vout, b_fd;
  logic [15:0] b_pc;
  logic [3:0]  b_act;

  int n_checks = 0, n_fail = 0;
  int rdy_pct = 100;
  int fd_cnt = 0, b_fd_cnt = 0;
  logic img [H][W];
  logic [F*SW-1:0] got_pc[$], exp_pc[$];
  logic [F-1:0]    got_act[$], exp_act[$];
  logic [15:0]     bq_pc[$];
  logic [3:0]      bq_act[$];
  logic            stalled = 1'b0;
  logic [F*SW-1:0] s_pc;
  logic [F-1:0]    s_act;

  bcnn_conv_mc #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K), .NUM_FILTERS(F)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_in(pixel_in), .valid_in(valid_in), .ready_in(ready_in),
    .xnor_mode(xnor_mode), .weight_bits(weight_bits), .threshold(threshold), .popcount(popcount),
    .act_bits(act_bits), .valid_out(valid_out), .out_ready(out_ready), .frame_done(frame_done));

  bcnn_conv_mc big (
    .clk(clk), .reset_n(reset_n), .pixel_in(b_pixel), .valid_in(b_valid), .ready_in(b_ready),
    .xnor_mode(1'b0), .weight_bits({4{9'h1FF}}), .threshold(16'h1111), .popcount(b_pc),
    .act_bits(b_act), .valid_out(b_vout), .out_ready(1'b1), .frame_done(b_fd));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(99) < rdy_pct);
  end

  always @(negedge clk) begin
    if (stalled) begin
      n_checks++;
      if (valid_out !== 1'b1 || popcount !== s_pc || act_bits !== s_act) begin
        n_fail++;
        $display("FAIL stall_hold: got valid=%b pc=%h act=%b, need 1 %h %b", valid_out, popcount, act_bits, s_pc, s_act);
      end
    end
    if (valid_out && !out_ready) begin
      n_checks++;
      if (ready_in !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ready: got ready_in=%b, need 0", ready_in);
      end
    end
    stalled = valid_out && !out_ready && reset_n;
    s_pc = popcount;
    s_act = act_bits;
    if (valid_out && out_ready) begin
      got_pc.push_back(popcount);
      got_act.push_back(act_bits);
    end
    if (frame_done) fd_cnt++;
    if (b_vout) begin
      bq_pc.push_back(b_pc);
      bq_act.push_back(b_act);
    end
    if (b_fd) b_fd_cnt++;
  end

  task automatic build_exp();
    for (int r = K-1; r < H; r++)
      for (int c = K-1; c < W; c++) begin
        logic [F*SW-1:0] pc;
        logic [F-1:0] a;
        pc = '0;
        a = '0;
        for (int f = 0; f < F; f++) begin
          int cnt;
          cnt = 0;
          for (int wr = 0; wr < K; wr++)
            for (int wc = 0; wc < K; wc++) begin
              logic p, w;
              p = img[r-K+1+wr][c-K+1+wc];
              w = weight_bits[f*K*K + wr*K + wc];
              cnt += xnor_mode ? int'(p == w) : int'(p & w);
            end
          pc[f*SW +: SW] = 4'(cnt);
          a[f] = cnt >= int'(threshold[f*SW +: SW]);
        end
        exp_pc.push_back(pc);
        exp_act.push_back(a);
      end
  endtask

  task automatic fill_img(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = mode == 1 ? 1'b1 : 1'($urandom_range(1));
  endtask

  task automatic send_frame(input int vpct, input int npix);
    for (int i = 0; i < npix; i++) begin
      logic acc;
      int t;
      while ($urandom_range(99) >= vpct) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
      end
      valid_in = 1'b1;
      pixel_in = img[i/W][i%W];
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = ready_in;
        @(posedge clk); #1;
        t++;
      end
      n_checks++;
      if (!acc) begin
        n_fail++;
        $display("FAIL handshake_timeout: pixel %0d got no ready_in in 200 cycles", i);
      end
    end
  endtask

  task automatic drain();
    valid_in = 1'b0;
    rdy_pct = 100;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    got_pc.delete(); got_act.delete(); exp_pc.delete(); exp_act.delete();
    fd_cnt = 0;
  endtask

  task automatic check_results(input string name, input int nfd);
    n_checks++;
    if (got_pc.size() != exp_pc.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d results, need %0d", name, got_pc.size(), exp_pc.size());
    end
    for (int i = 0; i < got_pc.size() && i < exp_pc.size(); i++) begin
      n_checks++;
      if (got_pc[i] !== exp_pc[i] || got_act[i] !== exp_act[i]) begin
        n_fail++;
        $display("FAIL %s_result[%0d]: got pc=%h act=%b, need pc=%h act=%b", name, i, got_pc[i], got_act[i], exp_pc[i], exp_act[i]);
      end
    end
    n_checks++;
    if (fd_cnt != nfd) begin
      n_fail++;
      $display("FAIL %s_frame_done: got %0d pulses, need %0d", name, fd_cnt, nfd);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || popcount !== '0 || act_bits !== '0 || frame_done !== 1'b0 || ready_in !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b pc=%h act=%b fd=%b rdy=%b, need 0 00 00 0 1", valid_out, popcount, act_bits, frame_done, ready_in);
    end
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_ones(input string name, input logic mode, input logic [F*SW-1:0] thr, input logic [F-1:0] act);
    start_test();
    fill_img(1);
    xnor_mode = mode;
    weight_bits = {9'h000, 9'h1FF};
    threshold = thr;
    for (int i = 0; i < 9; i++) begin
      exp_pc.push_back(8'h09);
      exp_act.push_back(act);
    end
    send_frame(100, W*H);
    drain();
    check_results(name, 1);
  endtask

  task automatic test_stall_random();
    start_test();
    fill_img(0);
    xnor_mode = 1'b1;
    weight_bits = {9'h0F3, 9'h1A5};
    threshold = {4'd4, 4'd5};
    build_exp();
    rdy_pct = 50;
    send_frame(70, W*H);
    drain();
    check_results("stall_random", 1);
  endtask

  task automatic test_back_to_back();
    start_test();
    xnor_mode = 1'b0;
    weight_bits = {9'h155, 9'h0BA};
    threshold = {4'd3, 4'd2};
    fill_img(0);
    build_exp();
    send_frame(100, W*H);
    fill_img(0);
    build_exp();
    send_frame(100, W*H);
    drain();
    check_results("back_to_back", 2);
  endtask

  task automatic test_reset_mid_frame();
    start_test();
    xnor_mode = 1'b0;
    weight_bits = {9'h1FF, 9'h1FF};
    threshold = {4'd1, 4'd1};
    fill_img(1);
    send_frame(100, 3*W + 2);
    n_checks++;
    if (valid_out !== 1'b1 || popcount !== 8'h99) begin
      n_fail++;
      $display("FAIL pre_reset_output: got v=%b pc=%h, need 1 99", valid_out, popcount);
    end
    valid_in = 1'b0;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || popcount !== '0 || act_bits !== '0 || ready_in !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b pc=%h act=%b rdy=%b, need 0 00 00 1", valid_out, popcount, act_bits, ready_in);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_test();
    fill_img(0);
    build_exp();
    send_frame(100, W*H);
    drain();
    check_results("after_reset", 1);
  endtask

  task automatic test_single_pixel();
    int ones;
    bq_pc.delete(); bq_act.delete();
    b_fd_cnt = 0;
    b_valid = 1'b1;
    for (int i = 0; i < 784; i++) begin
      b_pixel = (i == 10*28 + 10);
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (bq_pc.size() != 676) begin
      n_fail++;
      $display("FAIL big_count: got %0d results, need 676", bq_pc.size());
    end
    ones = 0;
    for (int i = 0; i < bq_pc.size() && i < 676; i++) begin
      int r, c;
      logic hit;
      r = i / 26 + 2;
      c = i % 26 + 2;
      hit = r >= 10 && r <= 12 && c >= 10 && c <= 12;
      if (hit) ones++;
      n_checks++;
      if (bq_pc[i] !== (hit ? 16'h1111 : 16'h0000) || bq_act[i] !== {4{hit}}) begin
        n_fail++;
        $display("FAIL big_result[%0d]: got pc=%h act=%b, need hit=%b", i, bq_pc[i], bq_act[i], hit);
      end
    end
    n_checks++;
    if (ones != 9 || b_fd_cnt != 1) begin
      n_fail++;
      $display("FAIL big_summary: got covering=%0d frame_done=%0d, need 9 1", ones, b_fd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ones("and_ones", 1'b0, {4'd0, 4'd5}, 2'b11);
    test_ones("xnor_ones", 1'b1, {4'd1, 4'd5}, 2'b01);
    test_stall_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_single_pixel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
